// File: rtl/gpio_ctrl.sv
// gpio_ctrl: register-mapped GPIO with pad-input synchronizer, per-bit edge interrupts
// and an optional per-bit input debouncer enabled by GPIO_DEBOUNCE_EN.
module gpio_ctrl #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bus_sel,
    input  logic             bus_we,
    input  logic [2:0]       bus_addr,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata,
    output logic             bus_ready,
    input  logic [WIDTH-1:0] gpio_ps,
    output logic [WIDTH-1:0] gpio_dr,
    output logic [WIDTH-1:0] gpio_ts,
    output logic             irq
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_in, level, prev, ie_q, is_q, edge_q, evt, wd;
    logic [31:0] rd_mux;
    logic wr, unused_wdata;

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign wd = bus_wdata[WIDTH-1:0];
    assign unused_wdata = ^bus_wdata;
    assign wr = bus_sel & bus_we;
    assign evt = (edge_q & level & ~prev) | (~edge_q & ~level & prev);

    always_comb
        rd_mux = bus_addr == 3'd0 ? 32'(gpio_dr) :
                 bus_addr == 3'd1 ? 32'(gpio_ts) :
                 bus_addr == 3'd2 ? 32'(level)   :
                 bus_addr == 3'd3 ? 32'(ie_q)    :
                 bus_addr == 3'd4 ? 32'(is_q)    :
                 bus_addr == 3'd5 ? 32'(edge_q)  : 32'h0;

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            sync_q <= '0;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_ps};

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);
    logic [CW-1:0] db_cnt [WIDTH];
    logic [WIDTH-1:0] db_q;
    assign level = db_q;

    // Level flips only after sync_in has disagreed for DB_CYCLES consecutive cycles
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            db_q <= '0;
            for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++)
                if (sync_in[i] == db_q[i])
                    db_cnt[i] <= '0;
                else if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
                    db_cnt[i] <= '0;
                    db_q[i]   <= sync_in[i];
                end else
                    db_cnt[i] <= db_cnt[i] + 1'b1;
        end
`else
    localparam int unused_db = DB_CYCLES;
    assign level = sync_in;
`endif

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            gpio_dr   <= '0;
            gpio_ts   <= '0;
            ie_q      <= '0;
            is_q      <= '0;
            edge_q    <= '0;
            prev      <= '0;
            irq       <= 1'b0;
            bus_ready <= 1'b0;
            bus_rdata <= '0;
        end else begin
            prev      <= level;
            irq       <= |(is_q & ie_q);
            bus_ready <= bus_sel;
            bus_rdata <= (bus_sel && !bus_we) ? rd_mux : 32'h0;
            // A new event overrides a simultaneous write-1-to-clear
            is_q      <= (is_q & ~((wr && bus_addr == 3'd4) ? wd : '0)) | evt;
            if (wr && bus_addr == 3'd0) gpio_dr <= wd;
            if (wr && bus_addr == 3'd1) gpio_ts <= wd;
            if (wr && bus_addr == 3'd3) ie_q    <= wd;
            if (wr && bus_addr == 3'd5) edge_q  <= wd;
        end
endmodule
